// File: rtl/ik_swift_pkg.sv
// Shared constants for the IK solver CSR block: DH column indices, FSM states,
// CTRL/STATUS bit positions and word-map helpers.
package ik_swift_pkg;

  localparam int unsigned THETA      = 0;
  localparam int unsigned L_OFFSET   = 1;
  localparam int unsigned L_DISTANCE = 2;
  localparam int unsigned ALPHA      = 3;
  localparam int unsigned NUM_DH     = 4;

  localparam int unsigned CTRL_GO    = 0;
  localparam int unsigned CTRL_IE    = 1;
  localparam int unsigned CTRL_CLR   = 2;
  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_ERR   = 2;

  localparam int unsigned WORD_TGT   = 0;
  localparam int unsigned WORD_JT    = 3;
  localparam int unsigned WORD_DH0   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    WAIT   = 2'd2
  } state_e;

  function automatic int unsigned ctrl_word(input int unsigned num_joints);
    return WORD_DH0 + NUM_DH * num_joints;
  endfunction

  function automatic int unsigned status_word(input int unsigned num_joints);
    return ctrl_word(num_joints) + 1;
  endfunction

  function automatic int unsigned num_words(input int unsigned num_joints);
    return ctrl_word(num_joints) + 2;
  endfunction

endpackage

// File: rtl/ik_swift_csr_decode.sv
// Splits a byte address into word index and byte lane, and flags mapped words.
module ik_swift_csr_decode
  import ik_swift_pkg::*;
#(
  parameter int unsigned NUM_JOINTS = 6,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic [ADDR_W-1:0] i_address,
  output logic [ADDR_W-3:0] o_word,
  output logic [1:0]        o_lane,
  output logic              o_valid
);

  assign o_word  = i_address[ADDR_W-1:2];
  assign o_lane  = i_address[1:0];
  assign o_valid = (32'(o_word) < num_words(NUM_JOINTS));

endmodule

// File: rtl/ik_swift_csr.sv
// Byte-wide CSR front end for the IK solver: shadow/active parameter banks and a
// GO/done handshake FSM. Define IK_CSR_READBACK_EN to read back shadow parameters.
module ik_swift_csr
  import ik_swift_pkg::*;
#(
  parameter int unsigned NUM_JOINTS = 6,
  parameter int unsigned WORD_W     = 27,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          chipselect,
  input  logic                                          write,
  input  logic                                          read,
  input  logic [ADDR_W-1:0]                             address,
  input  logic [7:0]                                    writedata,
  output logic [7:0]                                    readdata,
  output logic [2:0][WORD_W-1:0]                        target,
  output logic [NUM_JOINTS-1:0]                         joint_type,
  output logic [NUM_JOINTS-1:0][NUM_DH-1:0][WORD_W-1:0] dh_param,
  output logic                                          start,
  input  logic                                          done,
  output logic                                          busy,
  output logic                                          irq
);

  localparam int unsigned WIDX_W   = ADDR_W - 2;
  localparam int unsigned NWORD_SP = 1 << WIDX_W;
  localparam int unsigned CTRL_IDX = ctrl_word(NUM_JOINTS);
  localparam int unsigned STAT_IDX = status_word(NUM_JOINTS);

  logic [WIDX_W-1:0] w_word;
  logic [1:0]        w_lane;
  logic              w_valid;
  logic              w_wr;
  logic              w_rd;

  logic [WORD_W-1:0]     r_sh_tgt  [3];
  logic [NUM_JOINTS-1:0] r_sh_jt;
  logic [WORD_W-1:0]     r_sh_dh   [NUM_JOINTS][NUM_DH];
  logic [WORD_W-1:0]     r_act_tgt [3];
  logic [NUM_JOINTS-1:0] r_act_jt;
  logic [WORD_W-1:0]     r_act_dh  [NUM_JOINTS][NUM_DH];

  state_e r_state;
  state_e w_state_nxt;
  logic   r_ie, r_done, r_err;
  logic   r_start, r_busy, r_irq;
  logic [7:0] r_rdata;

  logic w_ctrl_wr, w_go, w_clr;
  logic w_go_idle, w_done_set, w_err_set;
  logic w_ie_nxt, w_done_nxt, w_err_nxt;

  logic [31:0] w_rb [NWORD_SP];
  logic [31:0] w_rd_word;
  logic [7:0]  w_rd_byte;

  ik_swift_csr_decode #(
    .NUM_JOINTS (NUM_JOINTS),
    .ADDR_W     (ADDR_W)
  ) u_decode (
    .i_address (address),
    .o_word    (w_word),
    .o_lane    (w_lane),
    .o_valid   (w_valid)
  );

  assign w_wr = chipselect & write & w_valid;
  assign w_rd = chipselect & read;

  // Overlay one byte lane onto a word; lane 0 covers whatever lies above bit 23.
  function automatic logic [WORD_W-1:0] merge_lane(input logic [WORD_W-1:0] cur,
                                                   input logic [1:0]        lane,
                                                   input logic [7:0]        data);
    logic [31:0] v;
    v = 32'(cur);
    case (lane)
      2'd0:    v[31:24] = data;
      2'd1:    v[23:16] = data;
      2'd2:    v[15:8]  = data;
      default: v[7:0]   = data;
    endcase
    return v[WORD_W-1:0];
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_sh_tgt
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sh_tgt[i] <= '0;
      end else if (w_wr && (w_word == WIDX_W'(WORD_TGT + i))) begin
        r_sh_tgt[i] <= merge_lane(r_sh_tgt[i], w_lane, writedata);
      end
    end
  end

  for (genvar j = 0; j < NUM_JOINTS; j++) begin : g_sh_dh_j
    for (genvar k = 0; k < NUM_DH; k++) begin : g_sh_dh_k
      always_ff @(posedge clk) begin
        if (reset) begin
          r_sh_dh[j][k] <= '0;
        end else if (w_wr && (w_word == WIDX_W'(WORD_DH0 + NUM_DH*j + k))) begin
          r_sh_dh[j][k] <= merge_lane(r_sh_dh[j][k], w_lane, writedata);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_jt <= '0;
    end else if (w_wr && (w_word == WIDX_W'(WORD_JT)) && (w_lane == 2'd3)) begin
      r_sh_jt <= writedata[NUM_JOINTS-1:0];
    end
  end

  // Active bank is a snapshot of the shadow bank taken during COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act_tgt <= '{default: '0};
      r_act_jt  <= '0;
      r_act_dh  <= '{default: '{default: '0}};
    end else if (r_state == COMMIT) begin
      r_act_tgt <= r_sh_tgt;
      r_act_jt  <= r_sh_jt;
      r_act_dh  <= r_sh_dh;
    end
  end

  assign w_ctrl_wr = w_wr && (w_word == WIDX_W'(CTRL_IDX)) && (w_lane == 2'd3);
  assign w_go      = w_ctrl_wr & writedata[CTRL_GO];
  assign w_clr     = w_ctrl_wr & writedata[CTRL_CLR];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go_idle   = 1'b0;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_state_nxt = COMMIT;
          w_go_idle   = 1'b1;
        end
      end
      COMMIT: begin
        w_state_nxt = WAIT;
        w_err_set   = w_go;
      end
      WAIT: begin
        w_err_set = w_go;
        if (done) begin
          w_state_nxt = IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as CLR takes priority.
  assign w_ie_nxt   = w_ctrl_wr ? writedata[CTRL_IE] : r_ie;
  assign w_done_nxt = w_done_set | (r_done & ~(w_clr | w_go_idle));
  assign w_err_nxt  = w_err_set | (r_err & ~w_clr);

  for (genvar i = 0; i < NWORD_SP; i++) begin : g_rb
    if (i == CTRL_IDX) begin : g_ctrl
      assign w_rb[i] = 32'(r_ie) << CTRL_IE;
    end else if (i == STAT_IDX) begin : g_stat
      assign w_rb[i] = (32'(r_busy) << STAT_BUSY) | (32'(r_done) << STAT_DONE)
                     | (32'(r_err) << STAT_ERR);
`ifdef IK_CSR_READBACK_EN
    end else if (i < 3) begin : g_tgt
      assign w_rb[i] = 32'(r_sh_tgt[i]);
    end else if (i == WORD_JT) begin : g_jt
      assign w_rb[i] = 32'(r_sh_jt);
    end else if (i < CTRL_IDX) begin : g_dh
      assign w_rb[i] = 32'(r_sh_dh[(i - WORD_DH0) / NUM_DH][(i - WORD_DH0) % NUM_DH]);
`endif
    end else begin : g_zero
      assign w_rb[i] = '0;
    end
  end

  assign w_rd_word = w_valid ? w_rb[w_word] : '0;

  always_comb begin
    w_rd_byte = '0;
    case (w_lane)
      2'd0:    w_rd_byte = w_rd_word[31:24];
      2'd1:    w_rd_byte = w_rd_word[23:16];
      2'd2:    w_rd_byte = w_rd_word[15:8];
      default: w_rd_byte = w_rd_word[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_irq   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ie    <= w_ie_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_start <= (r_state == COMMIT);
      r_busy  <= (w_state_nxt != IDLE);
      r_irq   <= w_ie_nxt & w_done_nxt;
      if (w_rd) begin
        r_rdata <= w_rd_byte;
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_out_tgt
    assign target[i] = r_act_tgt[i];
  end

  for (genvar j = 0; j < NUM_JOINTS; j++) begin : g_out_dh_j
    for (genvar k = 0; k < NUM_DH; k++) begin : g_out_dh_k
      assign dh_param[j][k] = r_act_dh[j][k];
    end
  end

  assign joint_type = r_act_jt;
  assign start      = r_start;
  assign busy       = r_busy;
  assign irq        = r_irq;
  assign readdata   = r_rdata;

endmodule

// File: tb/tb_ik_swift_csr.sv
// Scoreboard bench for ik_swift_csr: directed scenarios plus random bus traffic
// against a word-map level reference model.
module tb_ik_swift_csr;
  import ik_swift_pkg::*;

  localparam int unsigned N         = 6;
  localparam int unsigned W         = 27;
  localparam int unsigned A         = 8;
  localparam int          NWORDS    = 6 + 4*N;
  localparam int          CTRL_WORD = 4 + 4*N;
  localparam int          STAT_WORD = 5 + 4*N;
  localparam int          CTRL_ADDR = CTRL_WORD*4 + 3;
  localparam int          STAT_ADDR = STAT_WORD*4 + 3;
  localparam int          P_IDLE = 0, P_COMMIT = 1, P_WAIT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1, chipselect = 1'b0, write = 1'b0, read = 1'b0, done = 1'b0;
  logic [A-1:0] address = '0;
  logic [7:0] writedata = '0;
  logic [7:0] readdata;
  logic [2:0][W-1:0] target;
  logic [N-1:0] joint_type;
  logic [N-1:0][3:0][W-1:0] dh_param;
  logic start, busy, irq;

  ik_swift_csr #(.NUM_JOINTS(N), .WORD_W(W), .ADDR_W(A)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .target(target),
    .joint_type(joint_type), .dh_param(dh_param), .start(start), .done(done),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           start;
    logic           busy;
    logic           irq;
    logic [7:0]     rdata;
    logic [3*W-1:0] tgt;
    logic [N-1:0]   jt;
    logic [N*4*W-1:0] dh;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_sh_tgt[3], m_act_tgt[3];
  logic [W-1:0] m_sh_dh[N][4], m_act_dh[N][4];
  logic [N-1:0] m_sh_jt, m_act_jt;
  int   m_phase;
  bit   m_ie, m_done, m_err, m_start, m_busy, m_irq;
  logic [7:0] m_rdata;

  task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] put_byte(input logic [W-1:0] cur, input int lane,
                                            input logic [7:0] wd);
    logic [31:0] v;
    int s;
    s = 8 * (3 - lane);
    v = 32'(cur);
    v = (v & ~(32'hFF << s)) | (32'(wd) << s);
    return W'(v);
  endfunction

  function automatic logic [7:0] model_byte(input int addr);
    int word;
    int lane;
    logic [31:0] v;
    word = addr / 4;
    lane = addr % 4;
    v = '0;
    if (word == CTRL_WORD) v = 32'(m_ie) << 1;
    else if (word == STAT_WORD)
      v = 32'(m_phase != P_IDLE) | (32'(m_done) << 1) | (32'(m_err) << 2);
`ifdef IK_CSR_READBACK_EN
    else if (word < 3) v = 32'(m_sh_tgt[word]);
    else if (word == 3) v = 32'(m_sh_jt);
    else if (word < CTRL_WORD) v = 32'(m_sh_dh[(word-4)/4][(word-4)%4]);
`endif
    return 8'(v >> (8 * (3 - lane)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_sh_tgt[i] = '0; m_act_tgt[i] = '0; end
    for (int j = 0; j < N; j++)
      for (int k = 0; k < 4; k++) begin m_sh_dh[j][k] = '0; m_act_dh[j][k] = '0; end
    m_sh_jt = '0; m_act_jt = '0;
    m_phase = P_IDLE;
    {m_ie, m_done, m_err, m_start, m_busy, m_irq} = '0;
    m_rdata = '0;
  endtask

  task automatic model_step(input bit rst, input bit cs, input bit wr, input bit rd,
                            input int addr, input logic [7:0] wd, input bit dn);
    int word;
    int lane;
    bit go;
    bit clr;
    if (rst) begin
      model_reset();
      return;
    end
    word = addr / 4;
    lane = addr % 4;
    go = 0;
    clr = 0;
    if (cs && rd) m_rdata = model_byte(addr);
    m_start = (m_phase == P_COMMIT);
    if (m_phase == P_COMMIT) begin
      m_act_tgt = m_sh_tgt;
      m_act_dh  = m_sh_dh;
      m_act_jt  = m_sh_jt;
    end
    if (cs && wr && word < NWORDS) begin
      if (word < 3) m_sh_tgt[word] = put_byte(m_sh_tgt[word], lane, wd);
      else if (word == 3) begin
        if (lane == 3) m_sh_jt = wd[N-1:0];
      end else if (word < CTRL_WORD)
        m_sh_dh[(word-4)/4][(word-4)%4] = put_byte(m_sh_dh[(word-4)/4][(word-4)%4], lane, wd);
      else if (word == CTRL_WORD && lane == 3) begin
        go = wd[0];
        m_ie = wd[1];
        clr = wd[2];
      end
    end
    if (clr) begin m_done = 0; m_err = 0; end
    if (go && m_phase == P_IDLE) m_done = 0;
    if (go && m_phase != P_IDLE) m_err = 1;
    if (dn && m_phase == P_WAIT) m_done = 1;
    case (m_phase)
      P_IDLE:   if (go) m_phase = P_COMMIT;
      P_COMMIT: m_phase = P_WAIT;
      default:  if (dn) m_phase = P_IDLE;
    endcase
    m_busy = (m_phase != P_IDLE);
    m_irq  = m_ie & m_done;
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.start = m_start;
    e.busy  = m_busy;
    e.irq   = m_irq;
    e.rdata = m_rdata;
    e.tgt   = {m_act_tgt[2], m_act_tgt[1], m_act_tgt[0]};
    e.jt    = m_act_jt;
    e.dh    = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < 4; k++) e.dh[(j*4+k)*W +: W] = m_act_dh[j][k];
    return e;
  endfunction

  task automatic drive(input bit rst, input bit cs, input bit wr, input bit rd,
                       input int addr, input logic [7:0] wd, input bit dn);
    @(negedge clk);
    reset = rst; chipselect = cs; write = wr; read = rd;
    address = A'(addr); writedata = wd; done = dn;
    model_step(rst, cs, wr, rd, addr, wd, dn);
    exp_q.push_back(make_exp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic wr_byte(input int addr, input logic [7:0] wd);
    drive(0, 1, 1, 0, addr, wd, 0);
  endtask

  task automatic rd_byte(input int addr);
    drive(0, 1, 0, 1, addr, 8'h00, 0);
  endtask

  // Monitor: compares each post-edge DUT state with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_start", 1024'(start), 1024'(e.start));
        chk("sb_busy", 1024'(busy), 1024'(e.busy));
        chk("sb_irq", 1024'(irq), 1024'(e.irq));
        chk("sb_readdata", 1024'(readdata), 1024'(e.rdata));
        chk("sb_target", 1024'(target), 1024'(e.tgt));
        chk("sb_joint_type", 1024'(joint_type), 1024'(e.jt));
        chk("sb_dh_param", 1024'(dh_param), 1024'(e.dh));
      end
    end
  end

  initial begin
    int r;
    int addr;
    model_reset();
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    idle(1);
    chk("reset_busy", 1024'(busy), 1024'(0));
    chk("reset_readdata", 1024'(readdata), 1024'(0));

    // Target x load then GO: start two edges after the GO write
    wr_byte(0, 8'h05); wr_byte(1, 8'h12); wr_byte(2, 8'h34); wr_byte(3, 8'h56);
    wr_byte(CTRL_ADDR, 8'h01);
    idle(2);
    chk("go_start_pulse", 1024'(start), 1024'(1));
    chk("go_target_x", 1024'(target[0]), 1024'(27'h5123456));
    idle(1);
    chk("start_one_cycle", 1024'(start), 1024'(0));
    chk("wait_busy", 1024'(busy), 1024'(1));

    // Shadow write of dh[2][ALPHA] during WAIT leaves the active table alone
    wr_byte((4 + 4*2 + ALPHA)*4 + 3, 8'h77);
    idle(1);
    chk("dh_active_unchanged", 1024'(dh_param[2][ALPHA]), 1024'(0));
    rd_byte((4 + 4*2 + ALPHA)*4 + 3);
    idle(1);
`ifdef IK_CSR_READBACK_EN
    chk("dh_readback", 1024'(readdata), 1024'(8'h77));
`else
    chk("dh_readback_off", 1024'(readdata), 1024'(8'h00));
`endif

    // GO while busy: flagged, no second start
    wr_byte(CTRL_ADDR, 8'h01);
    idle(2);
    chk("no_second_start", 1024'(start), 1024'(0));
    rd_byte(STAT_ADDR);
    idle(1);
    chk("status_busy_err", 1024'(readdata), 1024'(8'h05));
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    rd_byte(STAT_ADDR);
    idle(1);
    chk("status_done_err", 1024'(readdata), 1024'(8'h06));

    // Interrupt on completion with IE, cleared by CLR
    wr_byte(CTRL_ADDR, 8'h03);
    idle(3);
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    idle(1);
    chk("irq_set", 1024'(irq), 1024'(1));
    wr_byte(CTRL_ADDR, 8'h04);
    idle(1);
    chk("irq_cleared", 1024'(irq), 1024'(0));

    // Reset during WAIT aborts; a later done is ignored
    wr_byte(CTRL_ADDR, 8'h01);
    idle(2);
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 1);
    idle(2);
    chk("abort_busy", 1024'(busy), 1024'(0));
    chk("abort_target", 1024'(target), 1024'(0));
    chk("abort_dh", 1024'(dh_param), 1024'(0));
    rd_byte(STAT_ADDR);
    idle(1);
    chk("abort_status", 1024'(readdata), 1024'(8'h00));

    // Unmapped word after STATUS reads zero
    wr_byte(CTRL_ADDR, 8'h02);
    rd_byte(CTRL_ADDR);
    idle(1);
    chk("ctrl_ie_read", 1024'(readdata), 1024'(8'h02));
    rd_byte((STAT_WORD + 1)*4 + 3);
    idle(1);
    chk("unmapped_read", 1024'(readdata), 1024'(8'h00));
`ifndef IK_CSR_READBACK_EN
    wr_byte(4*4 + 3, 8'h5A);
    rd_byte(CTRL_ADDR);
    rd_byte(4*4 + 3);
    idle(1);
    chk("dh_area_read_off", 1024'(readdata), 1024'(8'h00));
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        addr = int'($urandom_range(0, NWORDS*4 - 1));
        drive(0, 1, 1, bit'($urandom_range(0, 1)), addr, 8'($urandom), $urandom_range(0, 9) == 0);
      end else if (r < 52) begin
        drive(0, 1, 1, 0, CTRL_ADDR, 8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
      end else if (r < 80) begin
        addr = (r < 70) ? int'($urandom_range(0, NWORDS*4 - 1)) : int'($urandom_range(0, 255));
        drive(0, 1, 0, 1, addr, 8'h00, $urandom_range(0, 9) == 0);
      end else if (r < 81) begin
        drive(1, 0, 0, 0, 0, 8'h00, 0);
      end else begin
        drive(0, bit'($urandom_range(0, 1)), 0, 0, int'($urandom_range(0, 255)), 8'h00,
              $urandom_range(0, 4) == 0);
      end
    end
    idle(2);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ik_swift_csr.md
IK_SWIFT_CSR -- requirements
Module: ik_swift_csr

Interface
REQ-001 Parameter NUM_JOINTS, default 6: joint count; legal range 1..8.
REQ-002 Parameter WORD_W, default 27: fixed-point word width; legal range 17..32.
REQ-003 Parameter ADDR_W, default 8: byte-address width; must satisfy 2^ADDR_W >= 4*(6+4*NUM_JOINTS).
REQ-004 clk  input  1  clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 chipselect  input  1  bus select.
REQ-007 write  input  1  byte write strobe; valid only with chipselect.
REQ-008 read  input  1  byte read strobe; valid only with chipselect.
REQ-009 address  input  ADDR_W  byte address.
REQ-010 writedata  input  8  write byte.
REQ-011 readdata  output  8  registered read byte.
REQ-012 target  output  3xWORD_W  active (x,y,z) target.
REQ-013 joint_type  output  NUM_JOINTS  active joint-type vector; 1 = rotational.
REQ-014 dh_param  output  NUM_JOINTSx4xWORD_W  active DH table, ordered theta, offset, distance, alpha.
REQ-015 start  output  1  one-cycle pulse to the solver core.
REQ-016 done  input  1  one-cycle completion pulse from the solver core.
REQ-017 busy  output  1  high while a solve is outstanding.
REQ-018 irq  output  1  level interrupt.

Function
REQ-019 Word map: 4 bytes per word; word 0-2 target x/y/z; word 3 joint_type; words 4..4+4N-1 dh[j][k] at word 4+4j+k; word 4+4N CTRL; word 5+4N STATUS. Byte address is word*4 + lane; lane 0 is the MSB.
REQ-020 Lane 0 writes word bits WORD_W-1:24 from writedata[WORD_W-25:0]; lanes 1-3 write bits 23:16, 15:8 and 7:0; the joint_type word uses lane 3 only.
REQ-021 Parameter writes update a shadow copy only, are accepted in every FSM state, and have no effect on the active outputs.
REQ-022 Writes to unmapped addresses are ignored.
REQ-023 CTRL lane 3: bit0 GO, bit1 IE (stored), bit2 CLR (write-1-clears DONE and ERR); other lanes and bits are ignored.
REQ-024 STATUS lane 3 is read-only: bit0 BUSY, bit1 DONE (sticky), bit2 ERR (sticky); writes to STATUS are ignored.
REQ-025 FSM states are IDLE, COMMIT and WAIT.
REQ-026 IDLE + GO: go to COMMIT; DONE is cleared.
REQ-027 COMMIT: active <= shadow; start=1 for exactly this cycle; busy=1; next state is WAIT.
REQ-028 WAIT: busy=1; on done, return to IDLE and set DONE.
REQ-029 GO received in COMMIT or WAIT is ignored and sets ERR.
REQ-030 done received outside WAIT is ignored.
REQ-031 CLR in the same cycle as a DONE/ERR set: the set wins.
REQ-032 irq = IE & DONE.
REQ-033 Read: chipselect & read at cycle N puts the byte on readdata at cycle N+1; readdata holds its value otherwise.
REQ-034 Reads of unmapped addresses return 0x00.
REQ-035 Simultaneous read and write to the same address: read returns the pre-write value.

Reset
REQ-036 reset forces: FSM to IDLE; shadow and active registers, IE, DONE and ERR to 0; start, busy, irq and readdata to 0.
REQ-037 reset asserted in COMMIT or WAIT aborts the solve; a later done pulse is ignored.

Configuration
REQ-038 Macro IK_CSR_READBACK_EN defined: target, joint_type and DH words read back their shadow values.
REQ-039 Macro IK_CSR_READBACK_EN undefined: those words read 0x00, and only CTRL (IE in bit1) and STATUS are readable.

Structure
REQ-040 Package ik_swift_pkg holds the DH index constants (THETA, L_OFFSET, L_DISTANCE, ALPHA), the FSM state enum, the CTRL/STATUS bit positions and a word-offset function of NUM_JOINTS.
REQ-041 Sub-module ik_swift_csr_decode maps an address to a word index, lane and valid flag; it is combinational and instantiated once.

Verification
REQ-042 Write bytes 0x05,0x12,0x34,0x56 to addr 0-3, then GO -> start pulses once two cycles after the GO write; target[0]=0x5123456 (WORD_W=27).
REQ-043 Write dh[2][ALPHA] while in WAIT -> dh_param output unchanged until the next GO; readback shows the new value (macro defined).
REQ-044 GO during WAIT -> no second start pulse; STATUS reads 0x05 (BUSY, ERR); then done -> STATUS reads 0x06.
REQ-045 IE=1, then solve completes -> irq=1; write CTRL=0x04 (CLR) -> irq=0 on the next cycle.
REQ-046 reset pulse in WAIT, then done -> busy=0, STATUS=0x00, all outputs 0.
REQ-047 Read of word 5+4N+1 and of the DH area with the macro undefined -> readdata 0x00 one cycle after the read strobe.
